// File: rtl/channel_sequencer.sv
// Frame-aware channel sequencer: tags accepted samples with their channel index,
// flags tlast on the final channel, tracks frame sync and counts completed frames.
module channel_sequencer #(
  parameter int NUM_CH  = 32,
  parameter int CH_W    = 5,
  parameter int DATA_W  = 16,
  parameter int FRAME_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic [DATA_W-1:0]  s_tdata,
  input  logic               s_tsof,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [DATA_W-1:0]  m_tdata,
  output logic [CH_W-1:0]    m_tchan,
  output logic               m_tlast,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               sync_err,
  input  logic               err_clr,
  output logic               locked
);

  typedef enum logic {HUNT, RUN} state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t          state, state_nxt;
  logic [CH_W-1:0] ch_cnt, ch_cnt_nxt;
  logic [CH_W-1:0] emit_ch;
  logic            accept, emit, set_err, emit_last;

  // While hunting, the input is always drained; once running it follows the output slot.
  assign s_tready  = (state == HUNT) ? 1'b1 : (!m_tvalid || m_tready);
  assign accept    = s_tvalid && s_tready;
  assign locked    = (state == RUN);
  assign emit_last = emit && (emit_ch == LAST_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HUNT;
      ch_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ch_cnt <= ch_cnt_nxt;
    end
  end

  // An SOF always restarts the frame at channel 0; an SOF anywhere else is a sync error.
  always_comb begin
    state_nxt  = state;
    ch_cnt_nxt = ch_cnt;
    emit       = 1'b0;
    emit_ch    = '0;
    set_err    = 1'b0;
    if (accept) begin
      case (state)
        HUNT: begin
          if (s_tsof) begin
            emit      = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (s_tsof) begin
            emit    = 1'b1;
            set_err = (ch_cnt != '0);
          end else if (ch_cnt != '0) begin
            emit    = 1'b1;
            emit_ch = ch_cnt;
          end else begin
            set_err   = 1'b1;
            state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
      if (emit) ch_cnt_nxt = (emit_ch == LAST_CH) ? '0 : emit_ch + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tchan  <= '0;
      m_tlast  <= 1'b0;
    end else if (emit) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
      m_tchan  <= emit_ch;
      m_tlast  <= (emit_ch == LAST_CH);
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  // Frames are counted when the last channel is accepted; a new error beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      sync_err  <= 1'b0;
    end else begin
      if (emit_last) frame_cnt <= frame_cnt + FRAME_W'(1);
      if (set_err) sync_err <= 1'b1;
      else if (err_clr) sync_err <= 1'b0;
    end
  end

endmodule
